// File: rtl/mario_motion_if.sv
// Player-motion bundle: button/map inputs from the game logic, position and
// airborne status back out to the sprite selector and renderer.
interface mario_motion_if;
    logic        i_clk_phys;
    logic        i_left;
    logic        i_right;
    logic        i_jump;
    logic        i_level;
    logic [10:0] i_floor_y;
    logic [10:0] i_ceil_y;
    logic        i_block_left;
    logic        i_block_right;
    logic [10:0] o_x;
    logic [10:0] o_y;
    logic        o_airborne;
    logic [4:0]  o_vy;
    logic        o_bump;

    modport master (
        output i_clk_phys, i_left, i_right, i_jump, i_level,
               i_floor_y, i_ceil_y, i_block_left, i_block_right,
        input  o_x, o_y, o_airborne, o_vy, o_bump
    );

    modport slave (
        input  i_clk_phys, i_left, i_right, i_jump, i_level,
               i_floor_y, i_ceil_y, i_block_left, i_block_right,
        output o_x, o_y, o_airborne, o_vy, o_bump
    );
endinterface

// File: rtl/mario_motion.sv
// Player physics: walk and jump integration on rising edges of the slow
// physics clock, producing x/y feet position, vertical speed and airborne flag.
//   state     | meaning
//   ST_GROUND | standing on floor_y, may launch a jump
//   ST_RISE   | moving up, speed decays by GRAVITY each tick
//   ST_FALL   | moving down, speed grows to VMAX until the floor is met
module mario_motion #(
    parameter int X_MAX      = 640,
    parameter int WALK_STEP  = 2,
    parameter int JUMP_V     = 12,
    parameter int JUMP_V_BIG = 14,
    parameter int GRAVITY    = 1,
    parameter int VMAX       = 12,
    parameter int START_X    = 32,
    parameter int START_Y    = 400
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    mario_motion_if.slave bus
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [10:0]        r_x, w_x_nxt;
    logic [10:0]        r_y, w_y_nxt;
    logic [4:0]         r_vy, w_vy_nxt;
    logic               r_airborne;
    logic               r_bump, w_bump_nxt;
    logic               r_jump_armed, w_armed_nxt;
    logic               r_pre_phys;
    logic               w_tick;
    logic [11:0]        w_width, w_height, w_x_lim, w_x_up, w_y_sum, w_ceil_land;
    logic signed [11:0] w_top;
    logic [5:0]         w_vy_up;
    logic [4:0]         w_vy_dn, w_vy_rise;

    always_comb begin
        w_tick      = bus.i_clk_phys & ~r_pre_phys;
        w_width     = bus.i_level ? 12'd45 : 12'd40;
        w_height    = bus.i_level ? 12'd78 : 12'd42;
        w_x_lim     = 12'(X_MAX) - w_width;
        w_x_up      = {1'b0, r_x} + 12'(WALK_STEP);
        w_y_sum     = {1'b0, r_y} + {7'd0, r_vy};
        w_top       = $signed({1'b0, r_y}) - $signed(w_height) - $signed({7'd0, r_vy});
        w_ceil_land = {1'b0, bus.i_ceil_y} + w_height;
        w_vy_up     = {1'b0, r_vy} + 6'(GRAVITY);
        w_vy_dn     = (r_vy > 5'(GRAVITY)) ? (r_vy - 5'(GRAVITY)) : 5'd0;
        // Releasing jump early caps the remaining rise speed for a short hop
        w_vy_rise   = (~bus.i_jump && (w_vy_dn > 5'd4)) ? 5'd4 : w_vy_dn;

        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_vy_nxt    = r_vy;
        w_bump_nxt  = 1'b0;
        w_armed_nxt = r_jump_armed;

        if (w_tick) begin
            if (bus.i_left & ~bus.i_right & ~bus.i_block_left) begin
                w_x_nxt = (r_x < 11'(WALK_STEP)) ? 11'd0 : (r_x - 11'(WALK_STEP));
            end else if (bus.i_right & ~bus.i_left & ~bus.i_block_right) begin
                w_x_nxt = (w_x_up > w_x_lim) ? w_x_lim[10:0] : w_x_up[10:0];
            end else if ({1'b0, r_x} > w_x_lim) begin
                w_x_nxt = w_x_lim[10:0];
            end

            case (r_state)
                ST_GROUND: begin
                    if (~bus.i_jump) begin
                        w_armed_nxt = 1'b1;
                    end
                    if (bus.i_jump & r_jump_armed) begin
                        w_vy_nxt    = bus.i_level ? 5'(JUMP_V_BIG) : 5'(JUMP_V);
                        w_state_nxt = ST_RISE;
                        w_armed_nxt = 1'b0;
                    end else if (r_y < bus.i_floor_y) begin
                        w_vy_nxt    = 5'd0;
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_y_nxt = bus.i_floor_y;
                    end
                end
                ST_RISE: begin
                    if (w_top <= $signed({1'b0, bus.i_ceil_y})) begin
                        w_y_nxt     = w_ceil_land[11] ? 11'h7FF : w_ceil_land[10:0];
                        w_vy_nxt    = 5'd0;
                        w_bump_nxt  = 1'b1;
                        w_state_nxt = ST_FALL;
                    end else begin
                        w_y_nxt  = r_y - {6'd0, r_vy};
                        w_vy_nxt = w_vy_rise;
                        if (w_vy_rise == 5'd0) begin
                            w_state_nxt = ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (w_y_sum >= {1'b0, bus.i_floor_y}) begin
                        w_y_nxt     = bus.i_floor_y;
                        w_vy_nxt    = 5'd0;
                        w_state_nxt = ST_GROUND;
                    end else begin
                        w_y_nxt  = w_y_sum[10:0];
                        w_vy_nxt = (w_vy_up > 6'(VMAX)) ? 5'(VMAX) : w_vy_up[4:0];
                    end
                end
                default: begin
                    w_state_nxt = ST_GROUND;
                end
            endcase
        end
    end

    // pre_phys resets high so a clk_phys already high at reset release is ignored
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            r_state      <= ST_GROUND;
            r_x          <= 11'(START_X);
            r_y          <= 11'(START_Y);
            r_vy         <= 5'd0;
            r_airborne   <= 1'b0;
            r_bump       <= 1'b0;
            r_jump_armed <= 1'b0;
            r_pre_phys   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_vy         <= w_vy_nxt;
            r_airborne   <= (w_state_nxt != ST_GROUND);
            r_bump       <= w_bump_nxt;
            r_jump_armed <= w_armed_nxt;
            r_pre_phys   <= bus.i_clk_phys;
        end
    end

    assign bus.o_x        = r_x;
    assign bus.o_y        = r_y;
    assign bus.o_vy       = r_vy;
    assign bus.o_airborne = r_airborne;
    assign bus.o_bump     = r_bump;

endmodule

// File: tb/tb_mario_motion.sv
// Bench for mario_motion: directed scenarios plus random button/map stimulus,
// all checked against a per-tick arithmetic model of the player physics.
module tb_mario_motion;

    logic clk = 1'b0;
    logic rstn;
    mario_motion_if bus ();

    mario_motion dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    localparam int GROUND = 0;
    localparam int RISE   = 1;
    localparam int FALL   = 2;

    int n_cmp = 0;
    int n_err = 0;
    int m_x, m_y, m_vy, m_phase;
    bit m_armed;

    task automatic model_reset();
        m_x = 32; m_y = 400; m_vy = 0; m_phase = GROUND; m_armed = 0;
    endtask

    task automatic model_tick(output bit eb);
        int w, h, lim, fl, cl, top, nx, ny, nv, np;
        bit na;
        w  = bus.i_level ? 45 : 40;
        h  = bus.i_level ? 78 : 42;
        lim = 640 - w;
        fl = int'(bus.i_floor_y);
        cl = int'(bus.i_ceil_y);
        eb = 0;
        nx = m_x; ny = m_y; nv = m_vy; np = m_phase; na = m_armed;
        if (bus.i_left && !bus.i_right && !bus.i_block_left)
            nx = (m_x - 2 < 0) ? 0 : m_x - 2;
        else if (bus.i_right && !bus.i_left && !bus.i_block_right)
            nx = (m_x + 2 > lim) ? lim : m_x + 2;
        else if (m_x > lim)
            nx = lim;
        if (m_phase == GROUND) begin
            if (!bus.i_jump) na = 1;
            if (bus.i_jump && m_armed) begin
                nv = bus.i_level ? 14 : 12; np = RISE; na = 0;
            end else if (m_y < fl) begin
                nv = 0; np = FALL;
            end else begin
                ny = fl;
            end
        end else if (m_phase == RISE) begin
            top = m_y - h - m_vy;
            if (top <= cl) begin
                ny = (cl + h > 2047) ? 2047 : cl + h;
                nv = 0; eb = 1; np = FALL;
            end else begin
                ny = m_y - m_vy;
                nv = m_vy - 1;
                if (!bus.i_jump && nv > 4) nv = 4;
                if (nv == 0) np = FALL;
            end
        end else begin
            if (m_y + m_vy >= fl) begin
                ny = fl; nv = 0; np = GROUND;
            end else begin
                ny = m_y + m_vy;
                nv = (m_vy + 1 > 12) ? 12 : m_vy + 1;
            end
        end
        m_x = nx; m_y = ny; m_vy = nv; m_phase = np; m_armed = na;
    endtask

    // One physics edge; captures bump on the tick clk and the clk after it
    task automatic phys_tick(output logic b0, output logic b1);
        @(negedge clk); bus.i_clk_phys = 1'b1;
        @(posedge clk); #1 b0 = bus.o_bump;
        @(posedge clk); #1 b1 = bus.o_bump;
        @(negedge clk); bus.i_clk_phys = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic string dut_str(logic b0, logic b1);
        return $sformatf("x=%0d y=%0d vy=%0d air=%0d bump=%0d/%0d",
                         bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne, b0, b1);
    endfunction

    function automatic string mdl_str(bit eb);
        return $sformatf("x=%0d y=%0d vy=%0d air=%0d bump=%0d/0",
                         m_x, m_y, m_vy, m_phase != GROUND, eb);
    endfunction

    task automatic set_in(bit l, bit r, bit j, bit lv, int fl, int cl, bit bl, bit br);
        bus.i_left = l; bus.i_right = r; bus.i_jump = j; bus.i_level = lv;
        bus.i_floor_y = 11'(fl); bus.i_ceil_y = 11'(cl);
        bus.i_block_left = bl; bus.i_block_right = br;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.i_clk_phys = 1'b0;
        set_in(0, 1, 0, 0, 400, 0, 0, 0);
        #2 rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne, bus.o_bump} !==
            {11'd32, 11'd400, 5'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: got %s exp x=32 y=400 vy=0 air=0 bump=0", dut_str(bus.o_bump, 1'b0));
        end
        @(negedge clk); rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_airborne} !== {11'd32, 11'd400, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got %s exp x=32 y=400 air=0", dut_str(bus.o_bump, 1'b0));
        end
        model_reset();
    endtask

    task automatic test_walk();
        logic b0, b1; bit eb;
        set_in(0, 1, 0, 0, 400, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne, b0, b1} !==
                {11'(m_x), 11'(m_y), 5'(m_vy), m_phase != GROUND, eb, 1'b0}) begin
                n_err++;
                $display("FAIL walk tick %0d: got %s exp %s", i, dut_str(b0, b1), mdl_str(eb));
            end
        end
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne} !== {11'd72, 11'd400, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL walk_final: got %s exp x=72 y=400 vy=0 air=0", dut_str(1'b0, 1'b0));
        end
    endtask

    task automatic test_right_edge();
        logic b0, b1; bit eb;
        int guard = 0;
        set_in(0, 1, 0, 0, 400, 0, 0, 0);
        while (m_x < 598 && guard < 400) begin
            guard++;
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_x, bus.o_y, bus.o_airborne, b0} !==
                {11'(m_x), 11'(m_y), m_phase != GROUND, eb}) begin
                n_err++;
                $display("FAIL edge_walk tick %0d: got %s exp %s", guard, dut_str(b0, b1), mdl_str(eb));
            end
        end
        for (int i = 0; i < 10; i++) begin
            phys_tick(b0, b1); model_tick(eb);
        end
        n_cmp++;
        if (bus.o_x !== 11'd600) begin
            n_err++;
            $display("FAIL edge_clamp_small: got x=%0d exp x=600", bus.o_x);
        end
        bus.i_level = 1'b1;
        phys_tick(b0, b1); model_tick(eb);
        n_cmp++;
        if (bus.o_x !== 11'd595) begin
            n_err++;
            $display("FAIL edge_grow: got x=%0d exp x=595", bus.o_x);
        end
    endtask

    task automatic test_jump();
        logic b0, b1; bit eb;
        int guard = 0;
        set_in(0, 0, 0, 0, 400, 0, 0, 0);
        phys_tick(b0, b1); model_tick(eb);
        bus.i_jump = 1'b1;
        phys_tick(b0, b1); model_tick(eb);
        n_cmp++;
        if ({bus.o_y, bus.o_vy, bus.o_airborne} !== {11'(m_y), 5'(m_vy), m_phase != GROUND}) begin
            n_err++;
            $display("FAIL jump_launch: got %s exp %s", dut_str(b0, b1), mdl_str(eb));
        end
        phys_tick(b0, b1); model_tick(eb);
        n_cmp++;
        if ({bus.o_y, bus.o_vy, bus.o_airborne} !== {11'd388, 5'd11, 1'b1}) begin
            n_err++;
            $display("FAIL jump_tick1: got %s exp y=388 vy=11 air=1", dut_str(b0, b1));
        end
        while (bus.o_airborne === 1'b1 && guard < 60) begin
            guard++;
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne, b0, b1} !==
                {11'(m_x), 11'(m_y), 5'(m_vy), m_phase != GROUND, eb, 1'b0}) begin
                n_err++;
                $display("FAIL jump_arc tick %0d: got %s exp %s", guard, dut_str(b0, b1), mdl_str(eb));
            end
        end
        n_cmp++;
        if ({bus.o_y, bus.o_airborne} !== {11'd400, 1'b0}) begin
            n_err++;
            $display("FAIL jump_land: got %s exp y=400 air=0 within 60 ticks", dut_str(b0, b1));
        end
        for (int i = 0; i < 5; i++) begin
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_airborne, bus.o_vy, bus.o_y} !== {1'b0, 5'd0, 11'd400}) begin
                n_err++;
                $display("FAIL jump_no_repeat tick %0d: got %s exp y=400 vy=0 air=0", i, dut_str(b0, b1));
            end
        end
    endtask

    task automatic test_ceiling();
        logic b0, b1; bit eb;
        int guard = 0;
        set_in(0, 0, 0, 0, 400, 330, 0, 0);
        phys_tick(b0, b1); model_tick(eb);
        bus.i_jump = 1'b1;
        phys_tick(b0, b1); model_tick(eb);
        for (int i = 1; i <= 3; i++) begin
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_y, bus.o_vy, bus.o_airborne, b0, b1} !==
                {11'(m_y), 5'(m_vy), m_phase != GROUND, eb, 1'b0}) begin
                n_err++;
                $display("FAIL ceil tick %0d: got %s exp %s", i, dut_str(b0, b1), mdl_str(eb));
            end
        end
        n_cmp++;
        if ({bus.o_y, bus.o_vy, bus.o_airborne, b0, b1} !== {11'd372, 5'd0, 1'b1, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ceil_hit: got %s exp y=372 vy=0 air=1 bump=1/0", dut_str(b0, b1));
        end
        bus.i_jump = 1'b0;
        while (bus.o_airborne === 1'b1 && guard < 60) begin
            guard++;
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_y, bus.o_vy, bus.o_airborne, b0} !== {11'(m_y), 5'(m_vy), m_phase != GROUND, eb}) begin
                n_err++;
                $display("FAIL ceil_fall tick %0d: got %s exp %s", guard, dut_str(b0, b1), mdl_str(eb));
            end
        end
    endtask

    task automatic test_floor_drop();
        logic b0, b1; bit eb;
        int guard = 0;
        int vmax_seen = 0;
        set_in(0, 0, 0, 0, 480, 0, 0, 0);
        phys_tick(b0, b1); model_tick(eb);
        n_cmp++;
        if ({bus.o_airborne, bus.o_vy, bus.o_y} !== {1'b1, 5'd0, 11'd400}) begin
            n_err++;
            $display("FAIL drop_enter: got %s exp y=400 vy=0 air=1", dut_str(b0, b1));
        end
        while (bus.o_airborne === 1'b1 && guard < 40) begin
            guard++;
            phys_tick(b0, b1); model_tick(eb);
            if (int'(bus.o_vy) > vmax_seen) vmax_seen = int'(bus.o_vy);
            n_cmp++;
            if ({bus.o_y, bus.o_vy, bus.o_airborne} !== {11'(m_y), 5'(m_vy), m_phase != GROUND}) begin
                n_err++;
                $display("FAIL drop_fall tick %0d: got %s exp %s", guard, dut_str(b0, b1), mdl_str(eb));
            end
        end
        n_cmp++;
        if (vmax_seen != 12 || bus.o_y !== 11'd480 || bus.o_airborne !== 1'b0) begin
            n_err++;
            $display("FAIL drop_land: got max_vy=%0d %s exp max_vy=12 y=480 air=0",
                     vmax_seen, dut_str(b0, b1));
        end
    endtask

    task automatic test_random();
        logic b0, b1; bit eb;
        int floors[4] = '{380, 400, 440, 480};
        int ceils[4]  = '{0, 250, 300, 330};
        int fl = 480, cl = 0;
        bit lv = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) lv = ~lv;
            if ($urandom_range(0, 9) == 0) fl = floors[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) cl = ceils[$urandom_range(0, 3)];
            set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), lv,
                   fl, cl, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            phys_tick(b0, b1); model_tick(eb);
            n_cmp++;
            if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne, b0, b1} !==
                {11'(m_x), 11'(m_y), 5'(m_vy), m_phase != GROUND, eb, 1'b0}) begin
                n_err++;
                $display("FAIL random tick %0d: got %s exp %s", i, dut_str(b0, b1), mdl_str(eb));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic b0, b1; bit eb;
        int guard = 0;
        set_in(0, 0, 0, 0, 400, 0, 0, 0);
        while (bus.o_airborne === 1'b1 && guard < 60) begin
            guard++;
            phys_tick(b0, b1); model_tick(eb);
        end
        phys_tick(b0, b1); model_tick(eb);
        phys_tick(b0, b1); model_tick(eb);
        bus.i_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            phys_tick(b0, b1); model_tick(eb);
        end
        @(negedge clk); #2 rstn = 1'b1;
        #1;
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne} !== {11'd32, 11'd400, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_async: got %s exp x=32 y=400 vy=0 air=0", dut_str(bus.o_bump, 1'b0));
        end
        bus.i_clk_phys = 1'b1;
        bus.i_jump = 1'b0;
        bus.i_right = 1'b1;
        @(negedge clk); rstn = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        model_reset();
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_airborne} !== {11'd32, 11'd400, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_no_tick: got %s exp x=32 y=400 air=0", dut_str(bus.o_bump, 1'b0));
        end
        @(negedge clk); bus.i_clk_phys = 1'b0;
        @(posedge clk); #1;
        phys_tick(b0, b1); model_tick(eb);
        n_cmp++;
        if ({bus.o_x, bus.o_y, bus.o_vy, bus.o_airborne} !== {11'd34, 11'(m_y), 5'(m_vy), m_phase != GROUND}) begin
            n_err++;
            $display("FAIL reset_mid_first_tick: got %s exp %s", dut_str(b0, b1), mdl_str(eb));
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_right_edge();
        test_jump();
        test_ceiling();
        test_floor_drop();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
